// File: rtl/control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute and
// drives datapath enables, mux selects and ALU operation per state.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       equal,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [3:0] alu_op,
    output logic       retire,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    state_t state_q;
    state_t state_d;
    logic   unused_zero;

    assign unused_zero = zero;
    assign state       = state_q;

    // funct7_5 selects SUB only for register ops; immediates have no SUBI
    function automatic logic [3:0] alu_dec(
        input logic [2:0] f3,
        input logic       f7,
        input logic       is_r
    );
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = ALU_ADD;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d    = S_DECODE;
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                unique case (1'b1)
                    opcode == OP_LOAD,
                    opcode == OP_STORE:  state_d = S_MEMADR;
                    opcode == OP_R:      state_d = S_EXEC_R;
                    opcode == OP_I:      state_d = S_EXEC_I;
                    opcode == OP_BRANCH: state_d = S_BRANCH;
                    opcode == OP_JAL:    state_d = S_JAL;
                    default: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                state_d = S_MEMWB;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = 1'b1;
            end
            S_EXEC_R: begin
                state_d   = S_ALUWB;
                alu_src_a = 2'b10;
                alu_op    = alu_dec(funct3, funct7_5, 1'b1);
            end
            S_EXEC_I: begin
                state_d   = S_ALUWB;
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = alu_dec(funct3, funct7_5, 1'b0);
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_SUB;
                retire    = 1'b1;
                pc_write  = ((funct3 == 3'b000) && equal) ||
                            ((funct3 == 3'b001) && !equal);
            end
            S_JAL: begin
                state_d   = S_ALUWB;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // a reset cycle must never commit anything
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected cycle sequences
// built from the instruction class, compared every cycle.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       equal;
    logic       zero;
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [3:0] alu_op;
    logic       retire;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       irw;
        logic       mw;
        logic       rw;
        logic       adr;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic [3:0] alu;
        logic       ret;
    } step_t;

    step_t exp_q[$];

    control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .equal(equal), .zero(zero),
        .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
        .retire(retire), .state(state)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(
        int st, bit pcw, bit irw, bit mw, bit rw, bit adr,
        int a, int b, int rs, int alu, bit ret
    );
        step_t s;
        s.st = 4'(st); s.pcw = pcw; s.irw = irw; s.mw = mw; s.rw = rw;
        s.adr = adr; s.a = 2'(a); s.b = 2'(b); s.rs = 2'(rs);
        s.alu = 4'(alu); s.ret = ret;
        return s;
    endfunction

    // ISA-level mnemonic order indexed by funct3, mapped to ALU codes
    function automatic int exp_alu(bit [2:0] f3, bit f7, bit is_r);
        int tbl[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
        if (f3 == 3'd0 && is_r && f7) return 1;
        if (f3 == 3'd5 && f7) return 9;
        return tbl[f3];
    endfunction

    function automatic void model(bit [6:0] op, bit [2:0] f3, bit f7, bit eq);
        bit taken;
        exp_q.delete();
        exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 0));
        case (op)
            7'b0000011: begin
                exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
                exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
                exp_q.push_back(mk(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
                exp_q.push_back(mk(4, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
            end
            7'b0100011: begin
                exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
                exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
                exp_q.push_back(mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1));
            end
            7'b0110011: begin
                exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
                exp_q.push_back(mk(6, 0, 0, 0, 0, 0, 2, 0, 0,
                                   exp_alu(f3, f7, 1), 0));
                exp_q.push_back(mk(8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
            end
            7'b0010011: begin
                exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
                exp_q.push_back(mk(7, 0, 0, 0, 0, 0, 2, 1, 0,
                                   exp_alu(f3, f7, 0), 0));
                exp_q.push_back(mk(8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
            end
            7'b1100011: begin
                taken = (f3 == 3'd0 && eq) || (f3 == 3'd1 && !eq);
                exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
                exp_q.push_back(mk(9, taken, 0, 0, 0, 0, 2, 0, 0, 1, 1));
            end
            7'b1101111: begin
                exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
                exp_q.push_back(mk(10, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0));
                exp_q.push_back(mk(8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
            end
            default:
                exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        endcase
    endfunction

    function automatic step_t observe();
        step_t s;
        s.st = state; s.pcw = pc_write; s.irw = ir_write;
        s.mw = mem_write; s.rw = reg_write; s.adr = adr_src;
        s.a = alu_src_a; s.b = alu_src_b; s.rs = result_src;
        s.alu = alu_op; s.ret = retire;
        return s;
    endfunction

    // Entered mid-cycle with the DUT in FETCH; leaves it back in FETCH.
    task automatic run_instr(string name, bit [6:0] op, bit [2:0] f3,
                             bit f7, bit eq);
        step_t act;
        opcode = op; funct3 = f3; funct7_5 = f7; equal = eq;
        zero = 1'($urandom);
        model(op, f3, f7, eq);
        #1;
        foreach (exp_q[i]) begin
            act = observe();
            checks++;
            if (act !== exp_q[i]) begin
                errors++;
                $display("FAIL %s op=%b f3=%0d step %0d: got %h (state %0d) expected %h (state %0d)",
                         name, op, f3, i, act, act.st, exp_q[i], exp_q[i].st);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL %s return: state %0d expected 0", name, state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 0;
        equal = 0; zero = 0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if ({state, pc_write, ir_write, mem_write, reg_write, retire}
                !== 9'b0) begin
                errors++;
                $display("FAIL reset_hold: state=%0d en=%b%b%b%b%b expected 0/00000",
                         state, pc_write, ir_write, mem_write, reg_write, retire);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({state, ir_write, pc_write, alu_src_b, mem_write, reg_write}
            !== {4'd0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: state=%0d ir=%b pc=%b b=%b expected 0 1 1 10",
                     state, ir_write, pc_write, alu_src_b);
        end
    endtask

    task automatic test_r_type();
        run_instr("sub", 7'b0110011, 3'd0, 1'b1, 1'b0);
        run_instr("add", 7'b0110011, 3'd0, 1'b0, 1'b0);
        run_instr("sra", 7'b0110011, 3'd5, 1'b1, 1'b0);
        run_instr("addi_f7", 7'b0010011, 3'd0, 1'b1, 1'b0);
        run_instr("srai", 7'b0010011, 3'd5, 1'b1, 1'b0);
    endtask

    task automatic test_load_store();
        run_instr("lw", 7'b0000011, 3'd2, 1'b0, 1'b0);
        run_instr("sw", 7'b0100011, 3'd2, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        run_instr("beq_t", 7'b1100011, 3'd0, 1'b0, 1'b1);
        run_instr("beq_nt", 7'b1100011, 3'd0, 1'b0, 1'b0);
        run_instr("bne_eq", 7'b1100011, 3'd1, 1'b0, 1'b1);
        run_instr("bne_t", 7'b1100011, 3'd1, 1'b0, 1'b0);
        run_instr("blt", 7'b1100011, 3'd2, 1'b0, 1'b1);
    endtask

    task automatic test_jal_unknown();
        run_instr("jal", 7'b1101111, 3'd0, 1'b0, 1'b0);
        run_instr("nop0", 7'b0000000, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic abort_at(string name, int target);
        int cyc = 0;
        bit saw_mw = 0;
        opcode = 7'b0100011; funct3 = 3'd2; funct7_5 = 0; equal = 0;
        #1;
        while (state !== 4'(target) && cyc < 8) begin
            saw_mw |= (mem_write === 1'b1) && (state !== 4'(target));
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (state !== 4'(target)) begin
            errors++;
            $display("FAIL %s reach: state %0d expected %0d", name, state, target);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({pc_write, ir_write, mem_write, reg_write, retire} !== 5'b0) begin
            errors++;
            $display("FAIL %s reset_cycle: en=%b%b%b%b%b expected 00000", name,
                     pc_write, ir_write, mem_write, reg_write, retire);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || saw_mw) begin
            errors++;
            $display("FAIL %s after: state %0d mem_write_seen %b expected 0 0",
                     name, state, saw_mw);
        end
    endtask

    task automatic test_reset_abort();
        abort_at("abort_memadr", 2);
        abort_at("abort_memwrite", 5);
        run_instr("post_abort_lw", 7'b0000011, 3'd2, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit [6:0] ops[7] = '{7'b0000011, 7'b0100011, 7'b0110011,
                             7'b0010011, 7'b1100011, 7'b1101111, 7'b0};
        bit [6:0] op;
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 7'b0) op = 7'($urandom);
            run_instr("rand", op, 3'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load_store();
        test_branch();
        test_jal_unknown();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 opcode  input  7  instruction opcode from the instruction register; stable from DECODE until return to FETCH.
REQ-005 funct3  input  3  instruction funct3; same stability as opcode.
REQ-006 funct7_5  input  1  instruction bit 30; same stability as opcode.
REQ-007 equal  input  1  ALU equal flag, used only in BRANCH.
REQ-008 zero  input  1  ALU zero flag; unused.
REQ-009 pc_write  output  1  PC load enable.
REQ-010 ir_write  output  1  instruction register and old_pc load enable.
REQ-011 mem_write  output  1  data memory write enable.
REQ-012 reg_write  output  1  register file write enable.
REQ-013 adr_src  output  1  memory address: 0=PC, 1=result.
REQ-014 alu_src_a  output  2  00=PC, 01=old_pc, 10=rs1 register.
REQ-015 alu_src_b  output  2  00=rs2 register, 01=immediate, 10=constant 4.
REQ-016 result_src  output  2  00=alu_out register, 01=memory data, 10=ALU result.
REQ-017 alu_op  output  4  ALU operation: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
REQ-018 retire  output  1  one-cycle pulse in the final state of each instruction.
REQ-019 state  output  4  current state encoding (debug).

Function
REQ-020 States: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC_R 6, EXEC_I 7, ALUWB 8, BRANCH 9, JAL 10; codes 11-15 go to FETCH next cycle, all enables 0.
REQ-021 Transitions: FETCH->DECODE; DECODE by opcode: 0000011/0100011->MEMADR, 0110011->EXEC_R, 0010011->EXEC_I, 1100011->BRANCH, 1101111->JAL, other->FETCH.
REQ-022 MEMADR->MEMREAD if opcode 0000011, else MEMWRITE; MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH; EXEC_R/EXEC_I->ALUWB->FETCH; JAL->ALUWB; BRANCH->FETCH.
REQ-023 Defaults in every state unless listed: enables 0, selects 00, alu_op ADD, retire 0.
REQ-024 FETCH: adr_src 0, ir_write 1, pc_write 1, a 00, b 10, ADD, result_src 10.
REQ-025 DECODE: a 01, b 01, ADD (branch target into alu_out); retire 1 only for unrecognised opcode.
REQ-026 MEMADR: a 10, b 01, ADD. MEMREAD: adr_src 1, result_src 00. MEMWB: result_src 01, reg_write 1, retire 1.
REQ-027 MEMWRITE: adr_src 1, result_src 00, mem_write 1, retire 1.
REQ-028 EXEC_R: a 10, b 00; funct3 000->ADD (SUB if funct7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7_5), 110 OR, 111 AND.
REQ-029 EXEC_I: a 10, b 01; same mapping except funct3 000 always ADD.
REQ-030 ALUWB: result_src 00, reg_write 1, retire 1.
REQ-031 BRANCH: a 10, b 00, SUB, result_src 00, retire 1; pc_write = (funct3 000 & equal) | (funct3 001 & !equal); other funct3 -> pc_write 0.
REQ-032 JAL: a 01, b 10, ADD, result_src 00, pc_write 1.
REQ-033 All outputs are combinational from state and instruction inputs; no output depends on reset combinationally except as in REQ-035.
REQ-034 Latency in cycles: lw 5, sw 4, R/I 4, branch 3, jal 4, unrecognised 2.

Reset
REQ-035 While reset is high, pc_write, ir_write, mem_write, reg_write, retire are 0; state becomes FETCH on the edge reset is sampled high.
REQ-036 Reset in any state abandons the instruction; next state is FETCH, no write enable asserted in the reset cycle.

Verification
REQ-037 reset high 2 cycles then low -> state 0, all enables 0 during reset; first cycle after: ir_write 1, pc_write 1, alu_src_b 10.
REQ-038 opcode 0110011, funct3 000, funct7_5 1 -> states 0,1,6,8,0; alu_op 0001 in state 6; reg_write and retire 1 only in state 8.
REQ-039 opcode 0000011 -> states 0,1,2,3,4; adr_src 1 in 3; result_src 01, reg_write 1 in 4; opcode 0100011 -> 0,1,2,5 with mem_write 1 only in 5.
REQ-040 opcode 1100011 funct3 000 equal 1 -> pc_write 1 in state 9; funct3 001 equal 1 -> pc_write 0; funct3 010 -> pc_write 0.
REQ-041 opcode 1101111 -> states 0,1,10,8; pc_write 1 in 10, reg_write 1 in 8; opcode 0000000 -> 0,1,0 with retire 1 in 1.
REQ-042 reset asserted while in state 2 for sw -> state 0 next cycle; mem_write never 1 for that instruction.
